// File: rtl/ones_pkg.sv
// Shared defaults and FSM state type for the ones-count result buffer.
package ones_pkg;

  localparam int unsigned COUNT_W_DEF = 3;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned TOTAL_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/result_fifo.sv
// First-word fall-through FIFO holding captured ones-counts.
// A push while full is accepted only when a pop happens in the same cycle.
module result_fifo
  import ones_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [COUNT_W-1:0] push_data,
  input  logic               pop,
  output logic [COUNT_W-1:0] pop_data,
  output logic               full,
  output logic               empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [COUNT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               do_push, do_pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; only these are reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ones_result_buffer.sv
// Tracks upstream ones-count words, captures each finished count into a FIFO,
// keeps a saturating running total and sticky overflow / protocol-error flags.
module ones_result_buffer
  import ones_pkg::*;
#(
  parameter int unsigned COUNT_W = COUNT_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned TOTAL_W = TOTAL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] bit_count,
  input  logic               start,
  input  logic               done,
  output logic [COUNT_W-1:0] rd_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [TOTAL_W-1:0] total,
  output logic               busy,
  output logic               overflow,
  output logic               proto_err
);

  state_t             state_q, state_d;
  logic               done_d;
  logic               done_rise;
  logic               capture;
  logic               pop;
  logic               full, empty;
  logic               accept;
  logic [TOTAL_W:0]   sum;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               overflow_q, overflow_d;
  logic               proto_err_q, proto_err_d;

  assign done_rise = done & ~done_d;
  assign capture   = (state_q == BUSY) & done_rise;
  assign pop       = rd_valid & rd_ready;
  // A capture into a full FIFO survives only if a pop frees a slot this cycle.
  assign accept    = capture & (~full | pop);
  assign sum       = {1'b0, total_q} + {{(TOTAL_W + 1 - COUNT_W){1'b0}}, bit_count};

  // State register and edge-detect delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done_d  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_d  <= done;
    end
  end

  // Next state: start always wins; done_rise ends a word only without start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (!start && done_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == BUSY);
  end

  // Accumulator and sticky-flag next-state.
  always_comb begin
    total_d     = total_q;
    overflow_d  = overflow_q;
    proto_err_d = proto_err_q;
    if (accept) total_d = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
    if (capture && full && !pop) overflow_d = 1'b1;
    if ((state_q == IDLE) && done_rise && !start) proto_err_d = 1'b1;
  end

  // Accumulator and sticky-flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      total_q     <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      total_q     <= total_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign total     = total_q;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;
  assign rd_valid  = ~empty;

  result_fifo #(
    .DEPTH   (DEPTH),
    .COUNT_W (COUNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (bit_count),
    .pop       (pop),
    .pop_data  (rd_data),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_ones_result_buffer.sv
// Directed bench for ones_result_buffer with default parameters.
module tb_ones_result_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] bit_count;
  logic       start;
  logic       done;
  logic [2:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] total;
  logic       busy;
  logic       overflow;
  logic       proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ones_result_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .bit_count (bit_count),
    .start     (start),
    .done      (done),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .total     (total),
    .busy      (busy),
    .overflow  (overflow),
    .proto_err (proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; done = 1'b0; bit_count = '0; rd_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One word: start pulse, done rises 'gap' cycles after start is sampled.
  task automatic do_word(input logic [2:0] v, input int gap, input logic rdy_cap);
    start = 1'b1; done = 1'b0;
    tick();
    start = 1'b0;
    repeat (gap - 1) tick();
    done = 1'b1; bit_count = v; rd_ready = rdy_cap;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, rd_valid, total, overflow, proto_err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: busy=%0b rd_valid=%0b total=%0d ovf=%0b perr=%0b required all 0",
               busy, rd_valid, total, overflow, proto_err);
    end
  endtask

  task automatic test_single();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL single_busy[%0d]: got %0b required 1", i, busy);
      end
      if (i == 2) begin done = 1'b1; bit_count = 3'd3; end
      tick();
    end
    checks++;
    if ({busy, rd_valid, rd_data, total} !== {1'b0, 1'b1, 3'd3, 8'd3}) begin
      errors++;
      $display("FAIL single_result: busy=%0b rd_valid=%0b rd_data=%0d total=%0d required 0 1 3 3",
               busy, rd_valid, rd_data, total);
    end
  endtask

  task automatic test_fill_drain();
    logic [2:0] exp_vals [4];
    exp_vals = '{3'd1, 3'd2, 3'd3, 3'd4};
    do_reset();
    do_word(3'd1, 2, 1'b0);
    do_word(3'd2, 2, 1'b0);
    do_word(3'd3, 2, 1'b0);
    do_word(3'd4, 2, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL fill_no_ovf_at_4: got %0b required 0", overflow);
    end
    do_word(3'd4, 2, 1'b0);
    checks++;
    if ({overflow, total} !== {1'b1, 8'd10}) begin
      errors++; $display("FAIL fill_overflow: ovf=%0b total=%0d required 1 10", overflow, total);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd_valid, rd_data} !== {1'b1, exp_vals[i]}) begin
        errors++;
        $display("FAIL drain[%0d]: valid=%0b data=%0d required 1 %0d", i, rd_valid, rd_data,
                 exp_vals[i]);
      end
      tick();
    end
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty: rd_valid=%0b required 0", rd_valid);
    end
    tick();
    rd_ready = 1'b0;
    checks++;
    if ({rd_valid, overflow, total} !== {1'b0, 1'b1, 8'd10}) begin
      errors++;
      $display("FAIL ready_when_empty: valid=%0b ovf=%0b total=%0d required 0 1 10",
               rd_valid, overflow, total);
    end
  endtask

  task automatic test_full_pop();
    logic [2:0] exp_vals [4];
    exp_vals = '{3'd2, 3'd3, 3'd4, 3'd2};
    do_reset();
    do_word(3'd1, 2, 1'b0);
    do_word(3'd2, 2, 1'b0);
    do_word(3'd3, 2, 1'b0);
    do_word(3'd4, 2, 1'b0);
    do_word(3'd2, 2, 1'b1);
    checks++;
    if ({overflow, total} !== {1'b0, 8'd12}) begin
      errors++; $display("FAIL full_pop_flags: ovf=%0b total=%0d required 0 12", overflow, total);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd_valid, rd_data} !== {1'b1, exp_vals[i]}) begin
        errors++;
        $display("FAIL full_pop_drain[%0d]: valid=%0b data=%0d required 1 %0d", i, rd_valid,
                 rd_data, exp_vals[i]);
      end
      tick();
    end
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL full_pop_empty: rd_valid=%0b required 0", rd_valid);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 63; i++) do_word(3'd4, 1, 1'b1);
    checks++;
    if (total !== 8'd252) begin
      errors++; $display("FAIL sat_before: total=%0d required 252", total);
    end
    do_word(3'd4, 1, 1'b1);
    checks++;
    if (total !== 8'd255) begin
      errors++; $display("FAIL sat_reach: total=%0d required 255", total);
    end
    for (int i = 0; i < 6; i++) do_word(3'd4, 1, 1'b1);
    checks++;
    if ({total, overflow} !== {8'd255, 1'b0}) begin
      errors++; $display("FAIL sat_hold: total=%0d ovf=%0b required 255 0", total, overflow);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_protocol();
    do_reset();
    done = 1'b1; bit_count = 3'd6;
    tick();
    checks++;
    if ({proto_err, rd_valid, busy, total} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL proto_orphan_done: perr=%0b valid=%0b busy=%0b total=%0d required 1 0 0 0",
               proto_err, rd_valid, busy, total);
    end
    done = 1'b0;
    do_reset();
    start = 1'b1; done = 1'b1; bit_count = 3'd6;
    tick();
    checks++;
    if ({busy, proto_err, rd_valid} !== {1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL proto_start_wins: busy=%0b perr=%0b valid=%0b required 1 0 0",
               busy, proto_err, rd_valid);
    end
    start = 1'b0; done = 1'b0;
    tick();
    start = 1'b1; done = 1'b1; bit_count = 3'd5;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, rd_valid, rd_data, total} !== {1'b1, 1'b1, 3'd5, 8'd5}) begin
      errors++;
      $display("FAIL busy_start_and_done: busy=%0b valid=%0b data=%0d total=%0d required 1 1 5 5",
               busy, rd_valid, rd_data, total);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_word(3'd1, 2, 1'b0);
    do_word(3'd2, 2, 1'b0);
    start = 1'b1; done = 1'b0;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, rd_valid, total} !== {1'b1, 1'b1, 8'd3}) begin
      errors++;
      $display("FAIL pre_reset_state: busy=%0b valid=%0b total=%0d required 1 1 3",
               busy, rd_valid, total);
    end
    reset = 1'b1; done = 1'b1; bit_count = 3'd7;
    tick();
    reset = 1'b0; done = 1'b0;
    checks++;
    if ({busy, rd_valid, total, overflow, proto_err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid: busy=%0b valid=%0b total=%0d ovf=%0b perr=%0b required all 0",
               busy, rd_valid, total, overflow, proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_pop();
    test_saturation();
    test_protocol();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
